// File: rtl/fir_feeder.sv
// Feeds a handshaked FIR core from a 4-deep sample FIFO and loads its 4 coefficients on request.
// Define FIR_FEEDER_TIMEOUT_EN to add a 15-cycle watchdog on the modwait handshake (sticky timeout_err).
module fir_feeder #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sample,
    output logic              in_ready,
    input  logic              coeff_wr,
    input  logic [1:0]        coeff_addr,
    input  logic [COEF_W-1:0] coeff_wdata,
    input  logic              coeff_start,
    output logic              coeff_busy,
    output logic [DATA_W-1:0] sample_data,
    output logic              data_ready,
    output logic [COEF_W-1:0] fir_coefficient,
    output logic              load_coeff,
    input  logic              modwait,
    input  logic [DATA_W-1:0] fir_out,
    input  logic              err,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              result_err,
    output logic [2:0]        fifo_count,
    output logic              timeout_err
);

    localparam int DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        C_REQ  = 3'd3,
        C_WAIT = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;
    logic              push;
    logic              pop;
    logic [COEF_W-1:0] coeff [DEPTH];
    logic [1:0]        k;
    logic              timeout;

    assign in_ready   = (count != 3'd4);
    assign fifo_count = count;
    assign push       = in_valid && in_ready;
    // Pop only from IDLE on the registered count, so a fresh push is never bypassed to the core.
    assign pop        = (state == IDLE) && !coeff_start && (count != 3'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_sample;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                coeff[i] <= '0;
            end
        end else if (coeff_wr && !coeff_busy) begin
            coeff[coeff_addr] <= coeff_wdata;
        end
    end

`ifdef FIR_FEEDER_TIMEOUT_EN
    logic [3:0] wd_cnt;
    logic       wd_err;

    // Counter is zero on every non-request cycle, so it restarts on each entry to S_REQ/C_REQ.
    assign timeout     = ((state == S_REQ) || (state == C_REQ)) && !modwait && (wd_cnt == 4'd14);
    assign timeout_err = wd_err;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (((state == S_REQ) || (state == C_REQ)) && !modwait) begin
                wd_cnt <= wd_cnt + 4'd1;
            end else begin
                wd_cnt <= '0;
            end
            if (timeout) begin
                wd_err <= 1'b1;
            end
        end
    end
`else
    assign timeout     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state           <= IDLE;
            k               <= '0;
            sample_data     <= '0;
            fir_coefficient <= '0;
            data_ready      <= 1'b0;
            load_coeff      <= 1'b0;
            result_valid    <= 1'b0;
            result_data     <= '0;
            result_err      <= 1'b0;
            coeff_busy      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (coeff_start) begin
                        state           <= C_REQ;
                        k               <= '0;
                        fir_coefficient <= coeff[0];
                        load_coeff      <= 1'b1;
                        coeff_busy      <= 1'b1;
                    end else if (pop) begin
                        state       <= S_REQ;
                        sample_data <= fifo_mem[rd_ptr];
                        data_ready  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (modwait) begin
                        data_ready <= 1'b0;
                        state      <= S_WAIT;
                    end else if (timeout) begin
                        data_ready <= 1'b0;
                        state      <= IDLE;
                    end
                end
                S_WAIT: begin
                    if (!modwait) begin
                        result_data  <= fir_out;
                        result_err   <= err;
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end
                end
                C_REQ: begin
                    if (modwait) begin
                        load_coeff <= 1'b0;
                        state      <= C_WAIT;
                    end else if (timeout) begin
                        load_coeff <= 1'b0;
                        coeff_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                C_WAIT: begin
                    if (!modwait) begin
                        if (k != 2'd3) begin
                            k               <= k + 2'd1;
                            fir_coefficient <= coeff[k + 2'd1];
                            load_coeff      <= 1'b1;
                            state           <= C_REQ;
                        end else begin
                            coeff_busy <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_feeder.sv
// Self-checking bench for fir_feeder: vector table, hand sequences for FIFO/coefficient/reset corners,
// and a randomized run against a queue-based protocol model. Honours FIR_FEEDER_TIMEOUT_EN.
module tb_fir_feeder;

    logic        clk;
    logic        n_reset;
    logic        in_valid;
    logic [15:0] in_sample;
    logic        in_ready;
    logic        coeff_wr;
    logic [1:0]  coeff_addr;
    logic [15:0] coeff_wdata;
    logic        coeff_start;
    logic        coeff_busy;
    logic [15:0] sample_data;
    logic        data_ready;
    logic [15:0] fir_coefficient;
    logic        load_coeff;
    logic        modwait;
    logic [15:0] fir_out;
    logic        err;
    logic        result_valid;
    logic [15:0] result_data;
    logic        result_err;
    logic [2:0]  fifo_count;
    logic        timeout_err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [15:0] sample;
        int          d_rise;
        int          d_fall;
        logic [15:0] fout;
        logic        ferr;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] fill [5];

    logic [15:0] q [$];
    bit          busy, dr_m, in_wait, rv_m, acc;
    int          dly;
    logic [15:0] exp_s, exp_d;
    logic        exp_e;

    fir_feeder dut (
        .clk             (clk),
        .n_reset         (n_reset),
        .in_valid        (in_valid),
        .in_sample       (in_sample),
        .in_ready        (in_ready),
        .coeff_wr        (coeff_wr),
        .coeff_addr      (coeff_addr),
        .coeff_wdata     (coeff_wdata),
        .coeff_start     (coeff_start),
        .coeff_busy      (coeff_busy),
        .sample_data     (sample_data),
        .data_ready      (data_ready),
        .fir_coefficient (fir_coefficient),
        .load_coeff      (load_coeff),
        .modwait         (modwait),
        .fir_out         (fir_out),
        .err             (err),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_err      (result_err),
        .fifo_count      (fifo_count),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_data_ready"}, data_ready, 0);
        check({tag, "_load_coeff"}, load_coeff, 0);
        check({tag, "_coeff_busy"}, coeff_busy, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_result_data"}, result_data, 0);
        check({tag, "_result_err"}, result_err, 0);
        check({tag, "_sample_data"}, sample_data, 0);
        check({tag, "_fir_coefficient"}, fir_coefficient, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // One sample handshake as the FIR core would perform it, checking the single result strobe.
    task automatic serve(input logic [15:0] exp_sample, input int d_rise, input int d_fall,
                         input logic [15:0] fo, input logic fe,
                         input logic [15:0] want_d, input logic want_e);
        int          n;
        int          pulses;
        logic [15:0] rd;
        logic        re;
        n = 0;
        while (!data_ready && n < 20) begin
            tick();
            n++;
        end
        check("serve_dr_seen", data_ready, 1);
        check("serve_sample", sample_data, exp_sample);
        repeat (d_rise) tick();
        check("serve_dr_hold", data_ready, 1);
        check("serve_sample_hold", sample_data, exp_sample);
        modwait = 1'b1;
        fir_out = fo;
        err     = fe;
        tick();
        check("serve_dr_drop", data_ready, 0);
        repeat (d_fall - 1) tick();
        modwait = 1'b0;
        pulses = 0;
        rd = '0;
        re = 1'b0;
        repeat (4) begin
            tick();
            if (result_valid) begin
                pulses++;
                rd = result_data;
                re = result_err;
            end
        end
        check("serve_rv_pulses", pulses, 1);
        check("serve_result_data", rd, want_d);
        check("serve_result_err", re, want_e);
    endtask

    initial begin
        int acc_n;
        int exp_cnt;
        int n;
        bit rv_seen;

        n_checks    = 0;
        n_fail      = 0;
        n_reset     = 1'b0;
        in_valid    = 1'b0;
        in_sample   = '0;
        coeff_wr    = 1'b0;
        coeff_addr  = '0;
        coeff_wdata = '0;
        coeff_start = 1'b0;
        modwait     = 1'b0;
        fir_out     = '0;
        err         = 1'b0;

        vecs[0] = '{16'h1234, 3, 10, 16'h00AB, 1'b0, 16'h00AB, 1'b0};
        vecs[1] = '{16'hFFFF, 0, 1,  16'h8000, 1'b1, 16'h8000, 1'b1};
        vecs[2] = '{16'h0000, 1, 2,  16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
        vecs[3] = '{16'hA5A5, 5, 3,  16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        for (int i = 0; i < 5; i++) fill[i] = 16'(16'h2000 + i);

        repeat (3) tick();
        check_reset_outputs("reset");
        n_reset = 1'b1;
        tick();

        // Table: single samples through an empty FIFO, no bypass, one result each.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_sample = vecs[i].sample;
            tick();
            in_valid = 1'b0;
            check("vec_no_bypass_cnt", fifo_count, 1);
            check("vec_no_bypass_dr", data_ready, 0);
            serve(vecs[i].sample, vecs[i].d_rise, vecs[i].d_fall, vecs[i].fout, vecs[i].ferr,
                  vecs[i].exp_data, vecs[i].exp_err);
        end

        // FIFO fill with the core stalled on a prior sample.
        in_valid  = 1'b1;
        in_sample = 16'h1111;
        tick();
        in_valid = 1'b0;
        tick();
        check("full_p_dr", data_ready, 1);
        check("full_p_sample", sample_data, 16'h1111);
        acc_n = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid  = 1'b1;
            in_sample = fill[acc_n];
            if (in_ready) acc_n++;
            tick();
            exp_cnt = (c + 1 < 4) ? c + 1 : 4;
            check("full_cnt", fifo_count, exp_cnt);
            check("full_in_ready", in_ready, exp_cnt != 4);
        end
        check("full_accepted", acc_n, 4);
        modwait = 1'b1;
        tick();
        check("full_p_dr_drop", data_ready, 0);
        modwait = 1'b0;
        tick();
        check("full_p_rv", result_valid, 1);
        check("full_cnt_hold", fifo_count, 4);
        check("full_rdy_hold", in_ready, 0);
        tick();
        check("full_cnt_pop", fifo_count, 3);
        check("full_rdy_pop", in_ready, 1);
        check("full_pop_sample", sample_data, fill[0]);
        tick();
        check("full_cnt_5th", fifo_count, 4);
        check("full_rdy_5th", in_ready, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serve(fill[i], 1, 2, 16'(16'h3000 + i), 1'(i), 16'(16'h3000 + i), 1'(i));
        end
        check("full_drained", fifo_count, 0);

        // Coefficient load with samples queued; write during load is ignored.
        for (int a = 0; a < 4; a++) begin
            coeff_wr    = 1'b1;
            coeff_addr  = 2'(a);
            coeff_wdata = 16'(a + 1);
            tick();
        end
        coeff_wr  = 1'b0;
        in_valid  = 1'b1;
        in_sample = 16'h5555;
        tick();
        in_sample   = 16'h6666;
        coeff_start = 1'b1;
        tick();
        in_valid    = 1'b0;
        coeff_start = 1'b0;
        check("cl_queued", fifo_count, 2);
        for (int kk = 0; kk < 4; kk++) begin
            check("cl_load", load_coeff, 1);
            check("cl_coef", fir_coefficient, kk + 1);
            check("cl_busy", coeff_busy, 1);
            check("cl_no_dr", data_ready, 0);
            if (kk == 0) begin
                coeff_wr    = 1'b1;
                coeff_addr  = 2'd2;
                coeff_wdata = 16'hFFFF;
            end
            modwait = 1'b1;
            tick();
            coeff_wr = 1'b0;
            check("cl_load_drop", load_coeff, 0);
            check("cl_busy_wait", coeff_busy, 1);
            check("cl_coef_hold", fir_coefficient, kk + 1);
            tick();
            modwait = 1'b0;
            tick();
        end
        check("cl_busy_done", coeff_busy, 0);
        check("cl_load_done", load_coeff, 0);
        check("cl_dr_done", data_ready, 0);
        check("cl_cnt_done", fifo_count, 2);
        serve(16'h5555, 0, 1, 16'h0101, 1'b0, 16'h0101, 1'b0);
        serve(16'h6666, 2, 1, 16'h0202, 1'b1, 16'h0202, 1'b1);

        // Randomized traffic against a queue model of the feeder protocol.
        busy = 0; dr_m = 0; in_wait = 0; rv_m = 0; dly = 0;
        exp_s = '0; exp_d = '0; exp_e = 1'b0;
        q.delete();
        for (int c = 0; c < 500; c++) begin
            in_valid  = (c < 300) && ($urandom_range(0, 2) != 0);
            in_sample = 16'($urandom);
            if (dr_m && !modwait) begin
                if (dly == 0) begin
                    modwait = 1'b1;
                    fir_out = 16'($urandom);
                    err     = 1'($urandom);
                end else begin
                    dly--;
                end
            end else if (in_wait && modwait) begin
                if (dly == 0) modwait = 1'b0;
                else dly--;
            end
            acc  = in_valid && (q.size() < 4);
            rv_m = 0;
            if (!busy && q.size() > 0) begin
                exp_s = q.pop_front();
                busy  = 1;
                dr_m  = 1;
                dly   = $urandom_range(0, 4);
            end else if (dr_m && modwait) begin
                dr_m    = 0;
                in_wait = 1;
                dly     = $urandom_range(0, 4);
            end else if (in_wait && !modwait) begin
                in_wait = 0;
                busy    = 0;
                rv_m    = 1;
                exp_d   = fir_out;
                exp_e   = err;
            end
            if (acc) q.push_back(in_sample);
            tick();
            check("rnd_count", fifo_count, q.size());
            check("rnd_in_ready", in_ready, q.size() != 4);
            check("rnd_data_ready", data_ready, dr_m);
            check("rnd_result_valid", result_valid, rv_m);
            if (rv_m) begin
                check("rnd_result_data", result_data, exp_d);
                check("rnd_result_err", result_err, exp_e);
            end
            if (busy) check("rnd_sample_data", sample_data, exp_s);
        end
        in_valid = 1'b0;
        modwait  = 1'b0;
        check("rnd_drained", busy, 0);

        // Asynchronous reset in C_WAIT with k=2, then a fresh load sees zeroed coefficients.
        coeff_start = 1'b1;
        tick();
        coeff_start = 1'b0;
        for (int kk = 0; kk < 2; kk++) begin
            modwait = 1'b1;
            tick();
            modwait = 1'b0;
            tick();
        end
        check("rst_k2_coef", fir_coefficient, 3);
        modwait = 1'b1;
        tick();
        check("rst_k2_wait", load_coeff, 0);
        #2 n_reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        modwait = 1'b0;
        n_reset = 1'b1;
        tick();
        check_reset_outputs("post_rst");
        coeff_start = 1'b1;
        tick();
        coeff_start = 1'b0;
        for (int kk = 0; kk < 4; kk++) begin
            check("rl_load", load_coeff, 1);
            check("rl_coef_zero", fir_coefficient, 0);
            check("rl_busy", coeff_busy, 1);
            check("rl_no_rv", result_valid, 0);
            modwait = 1'b1;
            tick();
            check("rl_load_drop", load_coeff, 0);
            modwait = 1'b0;
            tick();
        end
        check("rl_busy_done", coeff_busy, 0);

        // Stalled handshake: watchdog when enabled, indefinite wait otherwise.
        in_valid  = 1'b1;
        in_sample = 16'h0F0F;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!data_ready && n < 10) begin
            tick();
            n++;
        end
        check("to_dr_rise", data_ready, 1);
        n = 0;
        rv_seen = 0;
        while (data_ready && n < 40) begin
            n++;
            tick();
            if (result_valid) rv_seen = 1;
        end
`ifdef FIR_FEEDER_TIMEOUT_EN
        check("to_dr_cycles", n, 15);
        check("to_dr_low", data_ready, 0);
        check("to_err", timeout_err, 1);
`else
        check("to_dr_cycles", n, 40);
        check("to_dr_high", data_ready, 1);
        check("to_err", timeout_err, 0);
`endif
        check("to_no_rv", rv_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_feeder.md
FIR_FEEDER -- requirements
Module: fir_feeder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: n_reset  in  1  asynchronous active-low reset.
REQ-003 SHALL have: in_valid  in  1  upstream sample offered; in_sample  in  16  sample value; in_ready  out  1  FIFO can accept.
REQ-004 SHALL have: coeff_wr  in  1  coefficient write strobe; coeff_addr  in  2  coefficient index; coeff_wdata  in  16  coefficient value; coeff_start  in  1  begin coefficient load; coeff_busy  out  1  load sequence active.
REQ-005 SHALL have filter-side ports: sample_data  out  16; data_ready  out  1; fir_coefficient  out  16; load_coeff  out  1; modwait  in  1; fir_out  in  16; err  in  1.
REQ-006 SHALL have: result_valid  out  1  one-cycle result strobe; result_data  out  16; result_err  out  1; fifo_count  out  3  FIFO occupancy 0..4; timeout_err  out  1  sticky watchdog flag.

Function
REQ-007 SHALL contain a 4-entry sample FIFO; push when in_valid && in_ready; in_ready = (fifo_count != 4).
REQ-008 SHALL have no push-to-pop bypass: a sample pushed into an empty FIFO is popped no earlier than the next cycle.
REQ-009 SHALL pop and push in the same cycle when FIFO is neither empty nor full; fifo_count unchanged.
REQ-010 SHALL hold a 4x16 coefficient register file; coeff_wr writes coeff_wdata to entry coeff_addr when coeff_busy=0; writes while coeff_busy=1 are ignored.
REQ-011 SHALL implement FSM states IDLE, S_REQ, S_WAIT, C_REQ, C_WAIT.
REQ-012 In IDLE, coeff_start=1 SHALL go to C_REQ with index k=0, taking priority over a non-empty FIFO; otherwise non-empty FIFO SHALL pop head into sample_data and go to S_REQ.
REQ-013 S_REQ SHALL drive data_ready=1 and hold sample_data stable until modwait=1, then go to S_WAIT with data_ready=0.
REQ-014 S_WAIT SHALL remain until modwait=0, then capture fir_out/err into result_data/result_err, pulse result_valid for exactly one cycle, and return to IDLE.
REQ-015 C_REQ SHALL drive fir_coefficient=coeff[k], load_coeff=1 until modwait=1, then go to C_WAIT with load_coeff=0.
REQ-016 C_WAIT SHALL wait for modwait=0; if k<3 increment k and go to C_REQ, else go to IDLE.
REQ-017 coeff_busy SHALL be 1 in C_REQ and C_WAIT only; coeff_start while not in IDLE SHALL be ignored.
REQ-018 data_ready and load_coeff SHALL be registered outputs and never both 1.
REQ-019 fir_coefficient SHALL hold its last value outside C_REQ; sample_data SHALL hold the last popped sample.

Reset
REQ-020 n_reset=0 SHALL asynchronously force: FSM=IDLE, FIFO empty, fifo_count=0, in_ready=1, k=0, all coefficients 0, sample_data=0, fir_coefficient=0, data_ready=0, load_coeff=0, result_valid=0, result_data=0, result_err=0, coeff_busy=0, timeout_err=0.
REQ-021 Reset mid-sequence SHALL discard queued samples and any partial coefficient load; no result_valid follows.

Configuration
REQ-022 Macro FIR_FEEDER_TIMEOUT_EN defined: a 4-bit counter runs in S_REQ/C_REQ; if modwait is not seen high within 15 cycles of entering the state, drop data_ready/load_coeff, set timeout_err=1 (sticky until reset), return to IDLE, emit no result_valid.
REQ-023 Macro undefined: S_REQ/C_REQ wait indefinitely; timeout_err tied to 0; no counter logic.

Verification
REQ-024 Push 0x1234 into empty FIFO, modwait rises 3 cycles after data_ready, falls 10 later with fir_out=0x00AB, err=0 -> sample_data=0x1234, one result_valid with result_data=0x00AB, result_err=0.
REQ-025 Push 5 samples back-to-back with modwait stuck 0 -> fifo_count reaches 4 then 3 after first pop, in_ready=0 only while count=4, 5th accepted after pop.
REQ-026 Write coeff 0x0001,0x0002,0x0003,0x0004, assert coeff_start with 2 samples queued -> four load_coeff pulses presenting 0x0001..0x0004 in order before any data_ready; coeff_busy=1 throughout.
REQ-027 coeff_wr to addr 2 with 0xFFFF during load -> entry 2 unchanged, loaded value remains 0x0003.
REQ-028 With FIR_FEEDER_TIMEOUT_EN, modwait held 0 after data_ready -> data_ready drops after 15 cycles, timeout_err=1, no result_valid; without macro data_ready stays 1.
REQ-029 Assert n_reset=0 during C_WAIT with k=2 -> all outputs at reset values immediately; after release next coeff_start loads from k=0 with coefficients 0x0000.
